// File: rtl/dm_responder.sv
// Wait-state data-memory responder for the load/store bus.
// One request per slot, serviced from a word-addressed RAM.
`timescale 1ns/1ps
module dm_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy,
    output logic              stall
);

    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              err_q;
    logic              err_nx;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic              wr_q;

    logic req;
    logic bad_op;
    logic bad_aln;
    logic bad_rng;
    logic illegal;
    logic access;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req     = mem_read | mem_write;
    assign bad_op  = mem_read & mem_write;
    assign bad_aln = |addr[1:0];
    assign bad_rng = |(addr >> (ADDR_W + 2));
    assign illegal = bad_op | bad_aln | bad_rng;
    assign access  = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_nx = RESP;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = WC;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = RESP;
                    err_nx   = 1'b0;
                end
            end
            RESP: begin
                state_nx = IDLE;
                err_nx   = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
                err_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    // Request fields are captured only in IDLE, so later input churn is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q <= '0;
            wd_q <= '0;
            wr_q <= 1'b0;
        end else if (state == IDLE && req) begin
            wa_q <= addr[ADDR_W+1:2];
            wd_q <= wdata;
            wr_q <= mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (access && !wr_q) begin
            rdata <= mem[wa_q];
        end
    end

    // RAM has no reset; reset forces IDLE so no write can fire while rst_n is low.
    always_ff @(posedge clk) begin
        if (access && wr_q) begin
            mem[wa_q] <= wd_q;
        end
    end

    assign ready = (state == RESP);
    assign err   = err_q & ready;
    assign busy  = (state != IDLE);
    assign stall = req & ~ready;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with 2 wait cycles,
// one with 0, checking latency, stall, errors and reset abort.
`timescale 1ns/1ps
module tb_dm_responder;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdt  [2];
    logic        rdy  [2];
    logic        er   [2];
    logic        bsy  [2];
    logic        stl  [2];

    int total = 0;
    int bad   = 0;

    dm_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdt[0]), .ready(rdy[0]), .err(er[0]),
        .busy(bsy[0]), .stall(stl[0])
    );

    dm_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdt[1]), .ready(rdy[1]), .err(er[1]),
        .busy(bsy[1]), .stall(stl[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rd[s] = r;
        wr[s] = w;
        ad[s] = a;
        wd[s] = d;
    endtask

    // Starts just before the sample edge; measures edges until ready.
    task automatic finish(input int s, input bit e_err,
                          input bit chk_rd, input logic [31:0] e_rd,
                          input bit flip, input logic [31:0] fa,
                          input logic [31:0] fd, input string tag);
        int n;
        int sc;
        int lat;
        lat = e_err ? 0 : ((s == 0) ? 3 : 1);
        n   = 0;
        sc  = 0;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(bsy[s]), 32'd1);
        if (flip) begin
            ad[s] = fa;
            wd[s] = fd;
        end
        while (!rdy[s] && n < 40) begin
            if (stl[s]) sc++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_stall_n"}, 32'(sc), 32'(lat));
        check({tag, "_stall_rdy"}, 32'(stl[s]), 32'd0);
        check({tag, "_err"}, 32'(er[s]), 32'(e_err));
        if (chk_rd) check({tag, "_rdata"}, rdt[s], e_rd);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_off"}, 32'(rdy[s]), 32'd0);
        check({tag, "_idle"}, 32'(bsy[s]), 32'd0);
    endtask

    task automatic acc(input int s, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit e_err, input bit chk_rd,
                       input logic [31:0] e_rd, input string tag);
        drive(s, r, w, a, d);
        finish(s, e_err, chk_rd, e_rd, 1'b0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
        end

        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_rdata", rdt[i], 32'h0);
            check("rst_ready", 32'(rdy[i]), 32'd0);
            check("rst_err", 32'(er[i]), 32'd0);
            check("rst_busy", 32'(bsy[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_rdy0", 32'(rdy[0]), 32'd0);
            check("idle_rdy1", 32'(rdy[1]), 32'd0);
        end

        acc(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, "w2_st10");
        acc(0, 0, 1, 32'h20, 32'h55AA55AA, 0, 0, 0, "w2_st20");
        acc(0, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "w2_ld10");

        acc(0, 1, 0, 32'h11, 32'h0, 1, 1, 32'hDEADBEEF, "e_mis");
        acc(0, 1, 0, 32'h400, 32'h0, 1, 1, 32'hDEADBEEF, "e_rng");
        acc(0, 1, 1, 32'h20, 32'hFFFFFFFF, 1, 1, 32'hDEADBEEF, "e_both");
        acc(0, 1, 0, 32'h20, 32'h0, 0, 1, 32'h55AA55AA, "e_reread");

        acc(1, 0, 1, 32'h000, 32'hA5A5A5A5, 0, 0, 0, "w0_st0");
        acc(1, 0, 1, 32'h3FC, 32'h12345678, 0, 0, 0, "w0_st3fc");
        acc(1, 1, 0, 32'h3FC, 32'h0, 0, 1, 32'h12345678, "w0_ld3fc");
        acc(1, 1, 0, 32'h000, 32'h0, 0, 1, 32'hA5A5A5A5, "w0_ld0");
        acc(1, 1, 0, 32'h401, 32'h0, 1, 1, 32'hA5A5A5A5, "w0_err");

        acc(0, 0, 1, 32'h44, 32'h77, 0, 0, 0, "fl_pre");
        drive(0, 0, 1, 32'h40, 32'h1);
        finish(0, 0, 0, 0, 1'b1, 32'h44, 32'h2, "fl_st");
        acc(0, 1, 0, 32'h40, 32'h0, 0, 1, 32'h1, "fl_ld40");
        acc(0, 1, 0, 32'h44, 32'h0, 0, 1, 32'h77, "fl_ld44");

        acc(0, 0, 1, 32'h80, 32'h0, 0, 0, 0, "rw_pre");
        drive(0, 0, 1, 32'h80, 32'hCAFEF00D);
        @(posedge clk);
        #1 check("rw_rdy_e0", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #2;
        check("rw_rdy_e1", 32'(rdy[0]), 32'd0);
        check("rw_busy_pre", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_busy_rst", 32'(bsy[0]), 32'd0);
        check("rw_rdy_rst", 32'(rdy[0]), 32'd0);
        check("rw_rdata_rst", rdt[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        finish(0, 0, 0, 0, 1'b0, 32'h0, 32'h0, "rw_again");
        acc(0, 1, 0, 32'h80, 32'h0, 0, 1, 32'hCAFEF00D, "rw_ld80");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
